// File: rtl/wam_pkg.sv
// wam_pkg: digit code constants and the active-low seven-segment decode table.
package wam_pkg;
    localparam logic [3:0] WAM_CODE_BLANK = 4'hA;
    localparam logic [3:0] WAM_CODE_OHI   = 4'hB;
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_OHI = 7'b0011100;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    function automatic logic [6:0] wam_decode(input logic [3:0] code);
        case (code)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            WAM_CODE_BLANK: return SEG_OFF;
            WAM_CODE_OHI: return SEG_OHI;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/wam_seg_dec.sv
// wam_seg_dec: combinational 4-bit digit code to active-low a..g segment pattern.
module wam_seg_dec
    import wam_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb seg = wam_decode(code);
endmodule

// File: rtl/wam_scan.sv
// wam_scan: self-timed N-digit seven-segment scanner with frame-synchronous double buffering,
// leading-zero blanking and anti-ghosting blank; WAM_SCAN_BLINK_EN adds per-digit blinking.
module wam_scan
    import wam_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int DWELL = 100000,
    parameter int BLANK = 4
`ifdef WAM_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] value,
    input  logic              load,
    input  logic              lzb_en,
`ifdef WAM_SCAN_BLINK_EN
    input  logic [NDIG-1:0]   blink,
`endif
    output logic [NDIG-1:0]   an,
    output logic [6:0]        a2g,
    output logic              frame
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] disp, pend;
    logic              pend_v, lzb, cnt_wrap, fb, blanking, z;
    logic [NDIG-1:0]   hide, blinked;
    logic [3:0]        code;
    logic [6:0]        seg;

    assign cnt_wrap = cnt == CW'(DWELL - 1);
    assign fb       = cnt_wrap && idx == IW'(NDIG - 1);
    assign blanking = cnt < CW'(BLANK);

`ifdef WAM_SCAN_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] fcnt;
    logic          phase;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (fb) begin
            fcnt  <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + 1'b1;
            phase <= phase ^ (fcnt == FW'(BLINK_FRAMES - 1));
        end

    assign blinked = phase ? blink : '0;
`else
    assign blinked = '0;
`endif

    // A digit is a leading zero only if it and every more-significant digit hold code 0.
    always_comb begin
        hide = '0;
        z = 1'b1;
        for (int i = NDIG - 1; i >= 0; i--) begin
            z = z && disp[4*i +: 4] == 4'h0;
            hide[i] = (lzb && z && i != 0) || blinked[i];
        end
    end

    assign code = hide[idx] ? WAM_CODE_BLANK : disp[4*idx +: 4];

    wam_seg_dec u_dec (.code(code), .seg(seg));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt    <= '0;
            idx    <= '0;
            disp   <= '0;
            pend   <= '0;
            pend_v <= 1'b0;
            lzb    <= 1'b0;
            frame  <= 1'b0;
            an     <= '1;
            a2g    <= '1;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap)
                idx <= fb ? '0 : idx + 1'b1;
            if (load)
                pend <= value;
            // A load on the frame boundary bypasses the pending buffer.
            if (fb) begin
                disp   <= load ? value : pend_v ? pend : disp;
                pend_v <= 1'b0;
                lzb    <= lzb_en;
            end else if (load)
                pend_v <= 1'b1;
            frame <= fb;
            an    <= blanking ? '1 : ~(NDIG'(1) << idx);
            a2g   <= blanking ? '1 : seg;
        end
endmodule
